// File: rtl/uart_tx_buffered.sv
// Buffered 8-bit UART transmitter: byte FIFO feeding an 8N1 (optionally even-parity)
// serial framer with a registered, glitch-free line output.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  output logic       full,
  output logic       empty,
  output logic       overflow,
  output logic       busy,
  output logic       sig_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  // FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;
  logic [7:0]       head;

  // Framer
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             sig_q, sig_d;
  logic             bit_done;

  assign full     = (count_q == DEPTH);
  assign empty    = (count_q == '0);
  assign overflow = overflow_q;
  assign sig_out  = sig_q;
  assign head     = mem_q[rd_ptr_q];
  assign bit_done = (cnt_q == BIT_LAST);

  // full is taken from the pre-edge count, so a pop on the same edge never frees room for a write
  assign push = wr_en && !full;
  assign pop  = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_done));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full);
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone decide what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // FSM: state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && (bit_idx_q == 3'd7)) state_d = PARITY_EN ? PARITY : STOP;
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done) state_d = empty ? IDLE : START;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs; the line value is registered below, so it trails the state by one cycle
  always_comb begin
    sig_d = 1'b1;
    busy  = (state_q != IDLE);
    case (state_q)
      START:   sig_d = 1'b0;
      DATA:    sig_d = shift_q[0];
      PARITY:  sig_d = parity_q;
      default: sig_d = 1'b1;
    endcase
  end

  // Bit timing and data path; the period counter restarts on every transition and bit boundary
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    if ((state_q == IDLE) || (state_d != state_q) || bit_done) cnt_d = '0;
    if (state_q != DATA)  bit_idx_d = '0;
    else if (bit_done)    bit_idx_d = bit_idx_q + 3'd1;
    if (pop) begin
      shift_d  = head;
      parity_d = ^head;
    end else if ((state_q == DATA) && bit_done) begin
      shift_d = {1'b0, shift_q[7:1]};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      sig_q     <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      sig_q     <= sig_d;
    end
  end

endmodule
